// File: rtl/unalign_seq.sv
// unalign_seq: sequential right-shift denormalizer with sticky bit.
//
// Undoes the leading-zero aligner. The value captured on the input is shifted
// right by a count, one count bit per cycle, starting at the MSB. The sticky
// output is the OR of every bit shifted out. Only one W-bit shift stage
// exists. It is reused with a shift distance of 2**step on each SHIFT cycle.
//
// Ports
//   clock      in   1        rising-edge clock
//   reset_n    in   1        asynchronous, active-low reset
//   in_valid   in   1        in/count valid
//   in_ready   out  1        high while idle (block can accept)
//   in         in   W        value to shift right
//   count      in   ORDER+1  unsigned right-shift amount
//   out_valid  out  1        out/sticky valid (result held until out_ready)
//   out_ready  in   1        consumer accepts the result
//   out        out  W        in >> count, zero fill
//   sticky     out  1        OR of the bits shifted out
module unalign_seq #(
  parameter int ORDER = 3,
  parameter int W     = 2**ORDER
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in,
  input  logic [ORDER:0]   count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
  output logic             sticky
);

  localparam int SW = (ORDER > 0) ? $clog2(ORDER + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [ORDER:0] cnt_q, cnt_d;
  logic [SW-1:0]  step_q, step_d;
  logic           stk_q, stk_d;
  logic [W-1:0]   out_q, out_d;
  logic           sticky_q, sticky_d;

  logic [W-1:0]   shifted;
  logic           lost;
  logic           take;
  int             sh;

  // The single shift stage. A distance of W or more drains acc completely,
  // and every remaining bit counts toward the sticky bit. Out-of-range source
  // bits are never indexed, so no X values or wrap-around can appear.
  always_comb begin
    shifted = '0;
    lost    = 1'b0;
    sh      = 1 << step_q;
    for (int i = 0; i < W; i++) begin
      if (i + sh < W) shifted[i] = acc_q[i + sh];
      if (i < sh)     lost       = lost | acc_q[i];
    end
  end

  assign take = cnt_q[step_q];

  // Next-state logic. The visible result registers (out_q/sticky_q) load only
  // on the last SHIFT edge. The working accumulator can therefore be reloaded
  // in IDLE without disturbing the previous result.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    stk_d    = stk_q;
    out_d    = out_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = in;
          cnt_d   = count;
          stk_d   = 1'b0;
          step_d  = SW'(ORDER);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (take) begin
          acc_d = shifted;
          stk_d = stk_q | lost;
        end
        if (step_q == '0) begin
          out_d    = acc_d;
          sticky_d = stk_d;
          state_d  = DONE;
        end else begin
          step_d = step_q - SW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      step_q   <= SW'(ORDER);
      stk_q    <= 1'b0;
      out_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      stk_q    <= stk_d;
      out_q    <= out_d;
      sticky_q <= sticky_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign sticky    = sticky_q;

endmodule

// File: tb/tb_unalign_seq.sv
// tb_unalign_seq: self-checking bench for unalign_seq.
//
// Two instances are used. One has ORDER=3, W=8 and covers directed cases,
// random cases, backpressure and abort. The other has ORDER=3, W=12 and is
// fed the output of a behavioural leading-zero aligner for the round-trip test.
module tb_unalign_seq;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_val;
  logic [3:0]  cnt_val;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_val;
  logic        sticky;

  logic        rt_in_valid;
  logic        rt_in_ready;
  logic [11:0] rt_in;
  logic [3:0]  rt_count;
  logic        rt_out_valid;
  logic [11:0] rt_out;
  logic        rt_sticky;

  int total;
  int bad;

  unalign_seq #(.ORDER(3), .W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_val), .count(cnt_val),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_val), .sticky(sticky)
  );

  unalign_seq #(.ORDER(3), .W(12)) dut_rt (
    .clock(clock), .reset_n(reset_n),
    .in_valid(rt_in_valid), .in_ready(rt_in_ready), .in(rt_in), .count(rt_count),
    .out_valid(rt_out_valid), .out_ready(1'b1), .out(rt_out), .sticky(rt_sticky)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: logical right shift, with sticky as the OR of the dropped bits.
  function automatic logic [7:0] model_out(input logic [7:0] v, input logic [3:0] c);
    return v >> c;
  endfunction

  function automatic logic model_sticky(input logic [7:0] v, input logic [3:0] c);
    logic [31:0] mask;
    mask = (32'd1 << c) - 32'd1;
    return |({24'd0, v} & mask);
  endfunction

  // Start one operation and wait (bounded) for the result to appear.
  // lat counts the edges after the accept edge up to the first out_valid.
  task automatic run_op(input logic [7:0] v, input logic [3:0] c,
                        output logic [7:0] o, output logic s, output int lat);
    int waits;
    @(negedge clock);
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clock);
      waits++;
    end
    in_val   = v;
    cnt_val  = c;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_val   = 8'($urandom);
    cnt_val  = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    o = out_val;
    s = sticky;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    total++;
    if (out_val !== 8'h00 || sticky !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_result: out=%h sticky=%b, required 00/0", out_val, sticky);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] vin  [6] = '{8'hB4, 8'hB4, 8'hB4, 8'hFF, 8'h80, 8'h00};
    logic [3:0] cin  [6] = '{4'd3, 4'd2, 4'd0, 4'd8, 4'd15, 4'd15};
    logic [7:0] eout [6] = '{8'h16, 8'h2D, 8'hB4, 8'h00, 8'h00, 8'h00};
    logic       estk [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] o;
    logic s;
    int lat;
    for (int k = 0; k < 6; k++) begin
      run_op(vin[k], cin[k], o, s, lat);
      total++;
      if (o !== eout[k] || s !== estk[k]) begin
        bad++;
        $display("[TB] FAIL directed_%0d: in=%h count=%0d got out=%h sticky=%b, required out=%h sticky=%b",
                 k, vin[k], cin[k], o, s, eout[k], estk[k]);
      end
      total++;
      if (lat !== 4) begin
        bad++;
        $display("[TB] FAIL latency_%0d: out_valid after %0d edges past accept, required 4", k, lat);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [7:0] v, o;
    logic [3:0] c;
    logic s;
    int lat;
    for (int k = 0; k < 24; k++) begin
      v = 8'($urandom);
      c = 4'($urandom);
      run_op(v, c, o, s, lat);
      total++;
      if (o !== model_out(v, c) || s !== model_sticky(v, c) || lat !== 4) begin
        bad++;
        $display("[TB] FAIL random_%0d: in=%h count=%0d got out=%h sticky=%b lat=%0d, required out=%h sticky=%b lat=4",
                 k, v, c, o, s, lat, model_out(v, c), model_sticky(v, c));
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] o;
    logic s;
    int lat;
    run_op(8'h5A, 4'd2, o, s, lat);
    total++;
    if (o !== 8'h16 || s !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_result: out=%h sticky=%b, required 16/1", o, s);
    end
    in_valid = 1'b1;
    in_val   = 8'h33;
    cnt_val  = 4'd1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      total++;
      if (out_val !== 8'h16 || sticky !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold_%0d: out=%h sticky=%b out_valid=%b in_ready=%b, required 16/1/1/0",
                 k, out_val, sticky, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    release_out();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    @(posedge clock);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_val !== 8'h16) begin
      bad++;
      $display("[TB] FAIL bp_not_taken: in_ready=%b out=%h, required 1/16", in_ready, out_val);
    end
  endtask

  task automatic test_abort();
    logic [7:0] o;
    logic s;
    int lat;
    @(negedge clock);
    in_val   = 8'hF3;
    cnt_val  = 4'd5;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_val !== 8'h00 || sticky !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_reset: in_ready=%b out_valid=%b out=%h sticky=%b, required 1/0/00/0",
               in_ready, out_valid, out_val, sticky);
    end
    @(negedge clock);
    reset_n = 1'b1;
    run_op(8'h40, 4'd1, o, s, lat);
    total++;
    if (o !== 8'h20 || s !== 1'b0 || lat !== 4) begin
      bad++;
      $display("[TB] FAIL abort_next: out=%h sticky=%b lat=%0d, required 20/0/4", o, s, lat);
    end
    release_out();
  endtask

  task automatic test_roundtrip();
    logic [11:0] v, a;
    logic [3:0]  c;
    int waits;
    for (int k = 0; k < 12; k++) begin
      v = 12'($urandom);
      if (k == 0) v = 12'h001;
      if (k == 1) v = 12'h800;
      a = v;
      c = 4'd0;
      while (!a[11] && c < 4'd12) begin
        a = a << 1;
        c = c + 4'd1;
      end
      @(negedge clock);
      rt_in       = a;
      rt_count    = c;
      rt_in_valid = 1'b1;
      @(posedge clock);
      #1;
      rt_in_valid = 1'b0;
      waits = 0;
      while (!rt_out_valid && waits < 20) begin
        @(posedge clock);
        #1;
        waits++;
      end
      total++;
      if (rt_out_valid !== 1'b1 || rt_out !== v || rt_sticky !== 1'b0) begin
        bad++;
        $display("[TB] FAIL roundtrip_%0d: aligned=%h count=%0d got out=%h sticky=%b valid=%b, required out=%h sticky=0",
                 k, a, c, rt_out, rt_sticky, rt_out_valid, v);
      end
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_val      = '0;
    cnt_val     = '0;
    out_ready   = 1'b0;
    rt_in_valid = 1'b0;
    rt_in       = '0;
    rt_count    = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_abort();
    test_roundtrip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
